// File: rtl/rdclk_word_sched.sv
// Read-side scheduler: arbitrates two byte FIFOs onto one packer and presents
// NB-byte words (or flushed partial words) to the APB read logic via valid/ack.
module rdclk_word_sched #(
   parameter int DW       = 8,
   parameter int NB       = 4,
   parameter int FLUSH_TO = 16
) (
   input  logic                    RdClk,
   input  logic                    PRESETn,
   input  logic                    Empty0,
   input  logic [DW-1:0]           RdData0,
   output logic                    RdEn0,
   input  logic                    Empty1,
   input  logic [DW-1:0]           RdData1,
   output logic                    RdEn1,
   output logic [NB*DW-1:0]        WordData,
   output logic                    WordValid,
   output logic                    WordCh,
   output logic [$clog2(NB+1)-1:0] WordBytes,
   input  logic                    WordAck
);

   localparam int CW = $clog2(NB + 1);
   localparam int IW = (FLUSH_TO > 1) ? $clog2(FLUSH_TO) : 1;
   localparam logic [CW-1:0] NB_C    = CW'(NB);
   localparam logic [IW-1:0] TO_LAST = IW'(FLUSH_TO - 1);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_HOLD} state_t;

   state_t            state, state_nxt;
   logic              grant, last_grant, arb_grant;
   logic              rd_en, rd_pend, word_full, flush;
   logic [CW-1:0]     issued, received;
   logic [IW-1:0]     idle_cnt;
   logic [NB*DW-1:0]  shreg;
   logic [DW-1:0]     cap_byte;

   // Tie goes to the channel not served last time.
   assign arb_grant = (~Empty0 & ~Empty1) ? ~last_grant : Empty0;
   assign cap_byte  = grant ? RdData1 : RdData0;

   always_comb begin
      rd_en = 1'b0;
      if (state == S_FILL && issued < NB_C)
         rd_en = grant ? ~Empty1 : ~Empty0;
   end

   assign RdEn0 = rd_en & ~grant;
   assign RdEn1 = rd_en & grant;

   // rd_pend marks the byte returning this cycle; the last capture closes the word.
   assign word_full = rd_pend && (received == NB_C - CW'(1));
   // Flush also waits out any strobe in this cycle so no issued byte is dropped.
   assign flush = (state == S_FILL) && (received != '0) && (issued == received) &&
                  !rd_en && (idle_cnt == TO_LAST);

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (~Empty0 | ~Empty1) state_nxt = S_FILL;
         S_FILL:  if (word_full || flush) state_nxt = S_HOLD;
         S_HOLD:  if (WordAck) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge RdClk or negedge PRESETn) begin
      if (!PRESETn) begin
         state      <= S_IDLE;
         grant      <= 1'b0;
         last_grant <= 1'b1;
         issued     <= '0;
         received   <= '0;
         idle_cnt   <= '0;
         shreg      <= '0;
         rd_pend    <= 1'b0;
      end else begin
         state   <= state_nxt;
         rd_pend <= rd_en;
         case (state)
            S_IDLE: begin
               shreg    <= '0;
               issued   <= '0;
               received <= '0;
               idle_cnt <= '0;
               if (~Empty0 | ~Empty1) begin
                  grant      <= arb_grant;
                  last_grant <= arb_grant;
               end
            end
            S_FILL: begin
               if (rd_en)
                  issued <= issued + CW'(1);
               if (rd_pend) begin
                  for (int unsigned i = 0; i < NB; i++)
                     if (received == CW'(i))
                        shreg[i*DW +: DW] <= cap_byte;
                  received <= received + CW'(1);
                  idle_cnt <= '0;
               end else if (idle_cnt != TO_LAST) begin
                  idle_cnt <= idle_cnt + IW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign WordData  = shreg;
   assign WordValid = (state == S_HOLD);
   assign WordCh    = grant;
   assign WordBytes = received;

endmodule

// File: tb/tb_rdclk_word_sched.sv
// Bench for rdclk_word_sched: vector table, corner-case sequences and random
// traffic checked against a word-level model of FIFO streams and arbitration.
module tb_rdclk_word_sched;
   localparam int DW       = 8;
   localparam int NB       = 4;
   localparam int FLUSH_TO = 16;
   localparam int CW       = $clog2(NB + 1);

   logic             RdClk   = 1'b0;
   logic             PRESETn = 1'b0;
   logic             Empty0  = 1'b1;
   logic             Empty1  = 1'b1;
   logic             WordAck = 1'b0;
   logic [DW-1:0]    RdData0 = '0;
   logic [DW-1:0]    RdData1 = '0;
   logic             RdEn0, RdEn1, WordValid, WordCh;
   logic [NB*DW-1:0] WordData;
   logic [CW-1:0]    WordBytes;

   rdclk_word_sched #(.DW(DW), .NB(NB), .FLUSH_TO(FLUSH_TO)) dut (
      .RdClk(RdClk), .PRESETn(PRESETn),
      .Empty0(Empty0), .RdData0(RdData0), .RdEn0(RdEn0),
      .Empty1(Empty1), .RdData1(RdData1), .RdEn1(RdEn1),
      .WordData(WordData), .WordValid(WordValid), .WordCh(WordCh),
      .WordBytes(WordBytes), .WordAck(WordAck)
   );

   always #5 RdClk = ~RdClk;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] q0[$], q1[$];     // FIFO contents still unread
   logic [DW-1:0] s0[$], s1[$];     // bytes not yet delivered in a word
   logic pause0 = 1'b0, pause1 = 1'b0;
   int   prun0 = 0, prun1 = 0;
   bit   toggle0 = 1'b0, rand_pause = 1'b0;
   int   ack_mode = 0;              // 0 low, 1 high, 2 random

   bit   m_idle = 1'b1, m_last = 1'b1, m_ch = 1'b0, held = 1'b0;
   int   m_bytes = 0, m_pulses = 0, words = 0;
   bit   ch_log[$];
   logic [NB*DW-1:0] h_data;
   logic h_ch;
   logic [CW-1:0] h_bytes;

   logic s_valid, s_ch;
   logic [NB*DW-1:0] s_data;
   logic [CW-1:0] s_bytes;

   typedef struct {
      int               n0;
      int               n1;
      bit               exp_ch;
      int               exp_bytes;
      logic [NB*DW-1:0] exp_data;
      int               exp_lat;
   } vec_t;
   vec_t tbl[7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic upd_empty();
      Empty0 = (q0.size() == 0) || pause0;
      Empty1 = (q1.size() == 0) || pause1;
   endtask

   task automatic load(input bit ch, input int n, input logic [DW-1:0] base, input logic [DW-1:0] inc);
      logic [DW-1:0] v;
      for (int k = 0; k < n; k++) begin
         v = base + DW'(k) * inc;
         if (ch) begin q1.push_back(v); s1.push_back(v); end
         else    begin q0.push_back(v); s0.push_back(v); end
      end
      upd_empty();
   endtask

   task automatic load_rand(input bit ch, input int n);
      logic [DW-1:0] v;
      for (int k = 0; k < n; k++) begin
         v = DW'($urandom);
         if (ch) begin q1.push_back(v); s1.push_back(v); end
         else    begin q0.push_back(v); s0.push_back(v); end
      end
      upd_empty();
   endtask

   // Word-level model: arbitration in idle, byte order per channel, handshake.
   task automatic monitor();
      logic [NB*DW-1:0] ed;
      int sz;
      chk("rden_overlap", {63'd0, RdEn0 & RdEn1}, 64'd0);
      if (RdEn0) chk("rden0_while_empty", {63'd0, Empty0}, 64'd0);
      if (RdEn1) chk("rden1_while_empty", {63'd0, Empty1}, 64'd0);
      if (m_idle) begin
         chk("rden_in_idle", {RdEn0, RdEn1}, 2'b00);
         if (!Empty0 || !Empty1) begin
            m_ch     = (!Empty0 && !Empty1) ? !m_last : Empty0;
            m_last   = m_ch;
            m_idle   = 1'b0;
            m_pulses = 0;
            sz       = m_ch ? q1.size() : q0.size();
            m_bytes  = (sz < NB) ? sz : NB;
         end
      end else if (!held && (RdEn0 || RdEn1)) begin
         chk("rden_channel", {63'd0, RdEn1}, {63'd0, m_ch});
         m_pulses++;
      end
      if (WordValid) begin
         chk("rden_in_hold", {RdEn0, RdEn1}, 2'b00);
         if (!held) begin
            held = 1'b1; h_data = WordData; h_ch = WordCh; h_bytes = WordBytes;
            chk("word_while_model_idle", {63'd0, m_idle}, 64'd0);
            chk("word_ch", {63'd0, WordCh}, {63'd0, m_ch});
            chk("word_bytes", WordBytes, m_bytes);
            chk("word_rd_pulses", m_pulses, m_bytes);
            ed = '0;
            for (int i = 0; i < m_bytes; i++) begin
               if (m_ch && s1.size() > 0)       ed[i*DW +: DW] = s1.pop_front();
               else if (!m_ch && s0.size() > 0) ed[i*DW +: DW] = s0.pop_front();
            end
            chk("word_data", WordData, ed);
            words++;
            ch_log.push_back(WordCh);
         end else begin
            chk("hold_stable", {WordData, WordCh, WordBytes}, {h_data, h_ch, h_bytes});
         end
         if (WordAck) begin held = 1'b0; m_idle = 1'b1; end
      end
   endtask

   // One RdClk cycle: sample/check at negedge, then play FIFO + consumer after posedge.
   task automatic step();
      logic p0, p1;
      @(negedge RdClk);
      p0 = RdEn0; p1 = RdEn1;
      s_valid = WordValid; s_data = WordData; s_ch = WordCh; s_bytes = WordBytes;
      monitor();
      @(posedge RdClk);
      #1;
      if (p0 && q0.size() > 0) RdData0 = q0.pop_front();
      if (p1 && q1.size() > 0) RdData1 = q1.pop_front();
      if (toggle0) pause0 = ~pause0;
      else if (rand_pause) begin
         if (prun0 < 3 && $urandom_range(3) == 0) begin pause0 = 1'b1; prun0++; end
         else begin pause0 = 1'b0; prun0 = 0; end
      end
      if (rand_pause) begin
         if (prun1 < 3 && $urandom_range(3) == 0) begin pause1 = 1'b1; prun1++; end
         else begin pause1 = 1'b0; prun1 = 0; end
      end
      case (ack_mode)
         0:       WordAck = 1'b0;
         1:       WordAck = 1'b1;
         default: WordAck = ($urandom_range(1) == 1);
      endcase
      upd_empty();
   endtask

   task automatic do_reset();
      #2 PRESETn = 1'b0;
      WordAck = 1'b0; ack_mode = 0; rand_pause = 1'b0; toggle0 = 1'b0;
      pause0 = 1'b0; pause1 = 1'b0; prun0 = 0; prun1 = 0;
      q0.delete(); q1.delete(); s0.delete(); s1.delete(); ch_log.delete();
      RdData0 = '0; RdData1 = '0;
      upd_empty();
      m_idle = 1'b1; m_last = 1'b1; held = 1'b0; words = 0;
      #1;
      chk("reset_outputs", {RdEn0, RdEn1, WordValid, WordCh, WordBytes, WordData}, 64'd0);
      @(posedge RdClk);
      #1 PRESETn = 1'b1;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      step();
      while (!s_valid && lat < 300) begin
         lat++;
         step();
      end
      chk("wait_valid_reached", {63'd0, s_valid}, 64'd1);
   endtask

   initial begin
      int lat, n;
      tbl[0] = '{4, 0, 1'b0, 4, 32'h44332211, 6};
      tbl[1] = '{0, 4, 1'b1, 4, 32'hDDCCBBAA, 6};
      tbl[2] = '{4, 4, 1'b0, 4, 32'h44332211, 6};
      tbl[3] = '{0, 2, 1'b1, 2, 32'h0000BBAA, 20};
      tbl[4] = '{1, 0, 1'b0, 1, 32'h00000011, 19};
      tbl[5] = '{3, 5, 1'b0, 3, 32'h00332211, 21};
      tbl[6] = '{7, 0, 1'b0, 4, 32'h44332211, 6};

      for (int i = 0; i < 7; i++) begin
         do_reset();
         load(1'b0, tbl[i].n0, 8'h11, 8'h11);
         load(1'b1, tbl[i].n1, 8'hAA, 8'h11);
         wait_valid(lat);
         chk("tbl_latency", lat, tbl[i].exp_lat);
         chk("tbl_ch", {63'd0, s_ch}, {63'd0, tbl[i].exp_ch});
         chk("tbl_bytes", s_bytes, tbl[i].exp_bytes);
         chk("tbl_data", s_data, tbl[i].exp_data);
         step();
         chk("tbl_held", {63'd0, s_valid}, 64'd1);
         WordAck = 1'b1;
         step();
         step();
         chk("tbl_ack_clears", {63'd0, s_valid}, 64'd0);
      end

      // Alternating grants with immediate ack.
      do_reset();
      load(1'b0, 8, 8'h11, 8'h11);
      load(1'b1, 8, 8'hA0, 8'h03);
      ack_mode = 1;
      n = 0;
      while (words < 4 && n < 300) begin step(); n++; end
      chk("alt_words", words, 4);
      for (int i = 0; i < 4; i++)
         if (i < ch_log.size()) chk("alt_grant_order", {63'd0, ch_log[i]}, i % 2);

      // Empty0 toggling every cycle while filling.
      do_reset();
      load(1'b0, 4, 8'h11, 8'h11);
      toggle0 = 1'b1;
      wait_valid(lat);
      chk("toggle_data", s_data, 32'h44332211);
      chk("toggle_bytes", s_bytes, 4);
      toggle0 = 1'b0; pause0 = 1'b0;
      WordAck = 1'b1;
      step();

      // Consumer stalls 50 cycles with both FIFOs loaded, then drains.
      do_reset();
      load(1'b0, 8, 8'h21, 8'h01);
      load(1'b1, 4, 8'h61, 8'h01);
      wait_valid(lat);
      for (int i = 0; i < 50; i++) step();
      chk("stall_still_valid", {63'd0, s_valid}, 64'd1);
      chk("stall_words", words, 1);
      ack_mode = 1;
      n = 0;
      while ((words < 3 || !m_idle) && n < 300) begin step(); n++; end
      chk("stall_drain_words", words, 3);
      for (int i = 0; i < 3; i++)
         if (i < ch_log.size()) chk("stall_grant_order", {63'd0, ch_log[i]}, i % 2);
      ack_mode = 0;
      step();
      step();
      // Ack held high while no word is valid must not disturb a pending flush.
      ack_mode = 1;
      load(1'b0, 2, 8'h5A, 8'h01);
      wait_valid(lat);
      chk("ack_ignored_latency", lat, 2 + 2 + FLUSH_TO);
      chk("ack_ignored_data", s_data, 32'h00005B5A);
      chk("ack_ignored_bytes", s_bytes, 2);
      ack_mode = 0;
      step();

      // Reset mid-word: two bytes captured, then async reset discards them.
      do_reset();
      load(1'b0, 8, 8'h11, 8'h11);
      for (int i = 0; i < 4; i++) step();
      chk("pre_reset_no_word", {63'd0, s_valid}, 64'd0);
      do_reset();
      load(1'b0, 4, 8'hC1, 8'h01);
      load(1'b1, 4, 8'hD1, 8'h01);
      wait_valid(lat);
      chk("post_reset_latency", lat, NB + 2);
      chk("post_reset_ch", {63'd0, s_ch}, 64'd0);
      chk("post_reset_data", s_data, 32'hC4C3C2C1);

      // Randomized traffic with pauses and random ack.
      for (int r = 0; r < 8; r++) begin
         do_reset();
         load_rand(1'b0, $urandom_range(12));
         load_rand(1'b1, $urandom_range(12));
         rand_pause = 1'b1;
         ack_mode = 2;
         n = 0;
         while (!(q0.size() == 0 && q1.size() == 0 && m_idle && !s_valid) && n < 3000) begin
            step();
            n++;
         end
         chk("rnd_bytes_delivered", s0.size() + s1.size(), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
